// File: rtl/ctrl_pkg.sv
// Shared decode constants, control bundle and stage FSM states for the ID control stage.
// Optional macro CTRL_EXT_ISA_EN adds the SRAV/SLTIU/LB/SB encodings.
// Pure declarations; no logic.
package ctrl_pkg;

  localparam int ALU_OP_W  = 4;
  localparam int RAM_SEL_W = 2;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL     = 6'd0;
  localparam logic [5:0] F_SRL     = 6'd2;
  localparam logic [5:0] F_SRA     = 6'd3;
  localparam logic [5:0] F_JR      = 6'd8;
  localparam logic [5:0] F_SYSCALL = 6'd12;
  localparam logic [5:0] F_ADD     = 6'd32;
  localparam logic [5:0] F_ADDU    = 6'd33;
  localparam logic [5:0] F_SUB     = 6'd34;
  localparam logic [5:0] F_AND     = 6'd36;
  localparam logic [5:0] F_OR      = 6'd37;
  localparam logic [5:0] F_NOR     = 6'd39;
  localparam logic [5:0] F_SLT     = 6'd42;
  localparam logic [5:0] F_SLTU    = 6'd43;

`ifdef CTRL_EXT_ISA_EN
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] F_SRAV   = 6'd7;
  localparam logic [RAM_SEL_W-1:0] RAM_BYTE = 2'b11;
`endif

  // ALU operation encodings
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1100;

  // Control bundle carried in the ID/EX register
  typedef struct packed {
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alu_src_b;
    logic                 signed_ext;
    logic                 reg_write;
    logic [4:0]           wb_reg;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic [RAM_SEL_W-1:0] ram_sel;
    logic                 beq;
    logic                 bne;
    logic                 jmp;
    logic                 jal;
    logic                 jr;
    logic                 syscall;
    logic                 illegal;
  } ctrl_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  // Bundle for an instruction that computes into a register through the ALU.
  function automatic ctrl_t ctrl_alu(input logic [ALU_OP_W-1:0] op, input logic src_b,
                                     input logic sext, input logic [4:0] wb);
    ctrl_t c;
    c            = '0;
    c.alu_op     = op;
    c.alu_src_b  = src_b;
    c.signed_ext = sext;
    c.reg_write  = 1'b1;
    c.wb_reg     = wb;
    return c;
  endfunction

endpackage

// File: rtl/id_ctrl_stage_if.sv
// ID-side and EX-side signals of the decode/control stage, grouped for port connection.
// master = the control stage, slave = surrounding pipeline.
// Handshake: id_ready consumes IF/ID, ex_ready lets ID/EX advance.
interface id_ctrl_stage_if;
  import ctrl_pkg::*;

  logic                 id_valid;
  logic [31:0]          id_instr;
  logic                 id_ready;
  logic                 ex_ready;
  logic                 flush;
  logic                 resume;
  logic                 ex_valid;
  logic [ALU_OP_W-1:0]  ex_alu_op;
  logic                 ex_alu_src_b;
  logic                 ex_signed_ext;
  logic                 ex_reg_write;
  logic [4:0]           ex_wb_reg;
  logic                 ex_mem_to_reg;
  logic                 ex_mem_write;
  logic [RAM_SEL_W-1:0] ex_ram_sel;
  logic                 ex_beq;
  logic                 ex_bne;
  logic                 ex_jmp;
  logic                 ex_jal;
  logic                 ex_jr;
  logic                 ex_syscall;
  logic                 ex_illegal;
  logic                 halted;

  modport master (
    input  id_valid, id_instr, ex_ready, flush, resume,
    output id_ready, ex_valid, ex_alu_op, ex_alu_src_b, ex_signed_ext, ex_reg_write,
           ex_wb_reg, ex_mem_to_reg, ex_mem_write, ex_ram_sel, ex_beq, ex_bne, ex_jmp,
           ex_jal, ex_jr, ex_syscall, ex_illegal, halted
  );

  modport slave (
    output id_valid, id_instr, ex_ready, flush, resume,
    input  id_ready, ex_valid, ex_alu_op, ex_alu_src_b, ex_signed_ext, ex_reg_write,
           ex_wb_reg, ex_mem_to_reg, ex_mem_write, ex_ram_sel, ex_beq, ex_bne, ex_jmp,
           ex_jal, ex_jr, ex_syscall, ex_illegal, halted
  );
endinterface

// File: rtl/ctrl_decode.sv
// Instruction -> control bundle plus source-register usage flags (CTRL_EXT_ISA_EN adds SRAV/SLTIU/LB/SB).
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        rs_used_o,
  output logic        rt_used_o
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt_rs;

  assign op   = instr_i[31:26];
  assign func = instr_i[5:0];
  assign rt   = instr_i[20:16];
  assign rd   = instr_i[15:11];
  // rs and shamt select datapath operands only; decode never looks at their values.
  assign unused_shamt_rs = ^{instr_i[25:21], instr_i[10:6]};

  // Decode table; unknown encodings collapse to an all-zero bundle flagged illegal.
  always_comb begin
    ctrl_t c;
    logic  legal;
    logic  rs_u;
    logic  rt_u;
    c     = '0;
    legal = 1'b1;
    rs_u  = 1'b0;
    rt_u  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_SLL:     begin c = ctrl_alu(ALU_SLL,  1'b0, 1'b0, rd); rt_u = 1'b1; end
          F_SRL:     begin c = ctrl_alu(ALU_SRL,  1'b0, 1'b0, rd); rt_u = 1'b1; end
          F_SRA:     begin c = ctrl_alu(ALU_SRA,  1'b0, 1'b0, rd); rt_u = 1'b1; end
`ifdef CTRL_EXT_ISA_EN
          F_SRAV:    begin c = ctrl_alu(ALU_SRA,  1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
`endif
          F_ADD,
          F_ADDU:    begin c = ctrl_alu(ALU_ADD,  1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_SUB:     begin c = ctrl_alu(ALU_SUB,  1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_AND:     begin c = ctrl_alu(ALU_AND,  1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_OR:      begin c = ctrl_alu(ALU_OR,   1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_NOR:     begin c = ctrl_alu(ALU_NOR,  1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_SLT:     begin c = ctrl_alu(ALU_SLT,  1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_SLTU:    begin c = ctrl_alu(ALU_SLTU, 1'b0, 1'b0, rd); rs_u = 1'b1; rt_u = 1'b1; end
          F_JR:      begin c.jr = 1'b1;      c.wb_reg = rd; rs_u = 1'b1; end
          F_SYSCALL: begin c.syscall = 1'b1; c.wb_reg = rd; end
          default:   legal = 1'b0;
        endcase
      end
      OP_J:     begin c.jmp = 1'b1; c.wb_reg = rt; end
      OP_JAL:   begin c.jal = 1'b1; c.reg_write = 1'b1; c.wb_reg = 5'd31; end
      OP_BEQ:   begin c.beq = 1'b1; c.signed_ext = 1'b1; c.wb_reg = rt; rs_u = 1'b1; rt_u = 1'b1; end
      OP_BNE:   begin c.bne = 1'b1; c.signed_ext = 1'b1; c.wb_reg = rt; rs_u = 1'b1; rt_u = 1'b1; end
      OP_ADDI:  begin c = ctrl_alu(ALU_ADD,  1'b1, 1'b1, rt); rs_u = 1'b1; end
      OP_ADDIU: begin c = ctrl_alu(ALU_ADD,  1'b1, 1'b0, rt); rs_u = 1'b1; end
      OP_SLTI:  begin c = ctrl_alu(ALU_SLT,  1'b1, 1'b1, rt); rs_u = 1'b1; end
`ifdef CTRL_EXT_ISA_EN
      OP_SLTIU: begin c = ctrl_alu(ALU_SLTU, 1'b1, 1'b0, rt); rs_u = 1'b1; end
      OP_LB: begin
        c = ctrl_alu(ALU_ADD, 1'b1, 1'b0, rt);
        c.mem_to_reg = 1'b1;
        c.ram_sel    = RAM_BYTE;
        rs_u         = 1'b1;
      end
      OP_SB: begin
        c.alu_op    = ALU_ADD;
        c.alu_src_b = 1'b1;
        c.mem_write = 1'b1;
        c.ram_sel   = RAM_BYTE;
        c.wb_reg    = rt;
        rs_u        = 1'b1;
        rt_u        = 1'b1;
      end
`endif
      OP_ANDI:  begin c = ctrl_alu(ALU_AND,  1'b1, 1'b1, rt); rs_u = 1'b1; end
      OP_ORI:   begin c = ctrl_alu(ALU_OR,   1'b1, 1'b1, rt); rs_u = 1'b1; end
      OP_LW: begin
        c = ctrl_alu(ALU_ADD, 1'b1, 1'b0, rt);
        c.mem_to_reg = 1'b1;
        rs_u         = 1'b1;
      end
      OP_SW: begin
        c.alu_op    = ALU_ADD;
        c.alu_src_b = 1'b1;
        c.mem_write = 1'b1;
        c.wb_reg    = rt;
        rs_u        = 1'b1;
        rt_u        = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      c         = '0;
      c.illegal = 1'b1;
      rs_u      = 1'b0;
      rt_u      = 1'b0;
    end
    // $0 is hardwired; a write to it is dropped here so hazard/forwarding logic never sees it.
    if (c.wb_reg == 5'd0) begin
      c.reg_write = 1'b0;
    end

    ctrl_o    = c;
    rs_used_o = rs_u;
    rt_used_o = rt_u;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX control register with load-use stall, EX flush and syscall drain/halt FSM (CTRL_EXT_ISA_EN widens decode).
// Latency: decoded controls appear on ex_* one cycle after id_ready & ex_ready.
// Backpressure: ex_ready=0 holds ID/EX and drops id_ready; stall/drain/halt also drop id_ready.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  id_ctrl_stage_if.master  bus
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

  ctrl_t            dec;
  logic             rs_used;
  logic             rt_used;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             load_use;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ex_q, ex_d;
  logic             ex_vld_q, ex_vld_d;
  logic             id_ready_c;

  ctrl_decode u_decode (
    .instr_i   (bus.id_instr),
    .ctrl_o    (dec),
    .rs_used_o (rs_used),
    .rt_used_o (rt_used)
  );

  assign id_rs = bus.id_instr[25:21];
  assign id_rt = bus.id_instr[20:16];

  // A load in EX whose result the ID instruction reads cannot be forwarded in time.
  assign load_use = bus.id_valid && ex_vld_q && ex_q.mem_to_reg && (ex_q.wb_reg != 5'd0) &&
                    ((rs_used && (id_rs == ex_q.wb_reg)) || (rt_used && (id_rt == ex_q.wb_reg)));

  // Next-state for FSM, drain counter and ID/EX; also the IF/ID consume signal.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_d       = ex_q;
    ex_vld_d   = ex_vld_q;
    id_ready_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          // Flush wins over stall and over EX backpressure: both stage contents are wrong-path.
          ex_d       = '0;
          ex_vld_d   = 1'b0;
          id_ready_c = bus.id_valid;
        end else if (bus.ex_ready) begin
          if (load_use) begin
            ex_d     = '0;
            ex_vld_d = 1'b0;
          end else begin
            ex_d       = bus.id_valid ? dec : '0;
            ex_vld_d   = bus.id_valid;
            id_ready_c = bus.id_valid;
            if (bus.id_valid && dec.syscall) begin
              state_d = ST_DRAIN;
              cnt_d   = CNT_LOAD;
            end
          end
        end
      end
      ST_DRAIN: begin
        // Only cycles where EX moves count towards the drain, so older instructions truly retire.
        if (bus.ex_ready) begin
          ex_d     = '0;
          ex_vld_d = 1'b0;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        ex_d     = '0;
        ex_vld_d = 1'b0;
        if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d  = ST_RUN;
        cnt_d    = '0;
        ex_d     = '0;
        ex_vld_d = 1'b0;
      end
    endcase
  end

  // State, counter and ID/EX register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      ex_q     <= '0;
      ex_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_q     <= ex_d;
      ex_vld_q <= ex_vld_d;
    end
  end

  assign bus.id_ready      = id_ready_c;
  assign bus.halted        = (state_q == ST_HALTED);
  assign bus.ex_valid      = ex_vld_q;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_alu_src_b  = ex_q.alu_src_b;
  assign bus.ex_signed_ext = ex_q.signed_ext;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_wb_reg     = ex_q.wb_reg;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_ram_sel    = ex_q.ram_sel;
  assign bus.ex_beq        = ex_q.beq;
  assign bus.ex_bne        = ex_q.bne;
  assign bus.ex_jmp        = ex_q.jmp;
  assign bus.ex_jal        = ex_q.jal;
  assign bus.ex_jr         = ex_q.jr;
  assign bus.ex_syscall    = ex_q.syscall;
  assign bus.ex_illegal    = ex_q.illegal;

endmodule
